uart_rx_core: RTL and testbench

UART_RX_CORE -- requirements
Module: uart_rx_core

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_rx_sync.sv | 42 ++++
 rtl/uart_rx_core.sv | 146 ++++++++++++++
 tb/tb_uart_rx_core.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and default sizing for the UART receive path.
package uart_pkg;

  localparam int DEF_DATA_BITS  = 8;
  localparam int DEF_OVERSAMPLE = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Front end of the receiver: metastability guard on rx and conversion of the
// baud8clk square wave into a one-clk sample tick.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic baud8clk,
  input  logic rx,
  output logic rx_s,
  output logic tick
);

  logic rx_meta_q, rx_meta_d;
  logic rx_s_q, rx_s_d;
  logic baud_prev_q, baud_prev_d;
  logic tick_q, tick_d;

  always_comb begin
    rx_meta_d   = rx;
    rx_s_d      = rx_meta_q;
    baud_prev_d = baud8clk;
    tick_d      = baud8clk & ~baud_prev_q;
  end

  // Synchronizer resets high so a reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      baud_prev_q <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      rx_meta_q   <= rx_meta_d;
      rx_s_q      <= rx_s_d;
      baud_prev_q <= baud_prev_d;
      tick_q      <= tick_d;
    end
  end

  assign rx_s = rx_s_q;
  assign tick = tick_q;

endmodule

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver: start/data/stop framing FSM plus a one-word
// holding register with valid/ready handshake and sticky overrun.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud8clk,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TCK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TCK_END  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  logic rx_s, tick;

  uart_rx_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .baud8clk (baud8clk),
    .rx       (rx),
    .rx_s     (rx_s),
    .tick     (tick)
  );

  rx_state_e            state_q, state_d;
  logic [TW-1:0]        tck_cnt_q, tck_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 done, ack;

  always_comb begin
    state_d     = state_q;
    tck_cnt_d   = tck_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    overrun_d   = overrun_q;
    frame_err_d = 1'b0;
    done        = 1'b0;

    if (tick) begin
      unique case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d   = START;
            tck_cnt_d = '0;
          end
        end
        START: begin
          if (tck_cnt_q == TCK_MID) begin
            if (rx_s) begin
              state_d = IDLE;
            end else begin
              state_d   = DATA;
              tck_cnt_d = '0;
              bit_cnt_d = '0;
            end
          end else begin
            tck_cnt_d = tck_cnt_q + TW'(1);
          end
        end
        DATA: begin
          if (tck_cnt_q == TCK_END) begin
            // LSB arrives first, so it ends up at bit 0 after DATA_BITS shifts.
            shreg_d   = {rx_s, shreg_q[DATA_BITS-1:1]};
            tck_cnt_d = '0;
            bit_cnt_d = bit_cnt_q + BW'(1);
            if (bit_cnt_q == BIT_LAST) state_d = STOP;
          end else begin
            tck_cnt_d = tck_cnt_q + TW'(1);
          end
        end
        STOP: begin
          if (tck_cnt_q == TCK_END) begin
            state_d     = IDLE;
            done        = rx_s;
            frame_err_d = ~rx_s;
          end else begin
            tck_cnt_d = tck_cnt_q + TW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    ack = rx_valid_q & rx_ready;
    if (ack) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end
    // A word consumed this very edge frees the holding register for the new one.
    if (done) begin
      if (!rx_valid_q || ack) begin
        rx_data_d  = shreg_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tck_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tck_cnt_q   <= tck_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: table of frames/acks with expected holding
// register state, plus hand sequences for false start and mid-frame reset.
module tb_uart_rx_core;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       baud8clk = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun;

  int errors = 0;
  int checks = 0;
  int fe_hi  = 0;

  uart_rx_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .baud8clk  (baud8clk),
    .rx        (rx),
    .rx_ready  (rx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // 4-clk baud square wave -> one tick every 4 clks, 32 clks per bit.
  initial begin
    forever begin
      repeat (2) @(negedge clk);
      baud8clk = ~baud8clk;
    end
  end

  always @(negedge clk) if (frame_err) fe_hi++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one full frame locked to a baud8clk rising edge. ack_at/rst_at
  // are negedge indices into the frame (-1 = unused).
  task automatic send_frame(input logic [7:0] data, input logic stop,
                            input int ack_at, input int rst_at);
    logic [9:0] bits;
    bits = {stop, data, 1'b0};
    @(posedge baud8clk);
    for (int i = 0; i < 320; i++) begin
      rx = bits[i / 32];
      rx_ready = (i == ack_at);
      if (i == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_data",  32'(rx_data),  32'h0);
        chk("rst_valid", 32'(rx_valid), 32'h0);
        chk("rst_ovr",   32'(overrun),  32'h0);
        chk("rst_fe",    32'(frame_err), 32'h0);
      end
      if (i == rst_at + 5) rst_n = 1'b1;
      @(negedge clk);
    end
    rx = 1'b1;
    rx_ready = 1'b0;
    repeat (32) @(negedge clk);
  endtask

  task automatic do_ack();
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  typedef struct {
    logic       is_ack;
    logic [7:0] data;
    logic       stop;
    int         ack_at;
    logic [7:0] exp_data;
    logic       exp_valid;
    logic       exp_ovr;
    int         exp_fe;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int fe0;
    // stop-bit sample of a frame lands on negedge index 309 -> posedge 310
    vecs[0]  = '{1'b0, 8'hA5, 1'b1, -1,  8'hA5, 1'b1, 1'b0, 0};
    vecs[1]  = '{1'b1, 8'h00, 1'b1, -1,  8'hA5, 1'b0, 1'b0, 0};
    vecs[2]  = '{1'b0, 8'h3C, 1'b0, -1,  8'hA5, 1'b0, 1'b0, 1};
    vecs[3]  = '{1'b0, 8'h11, 1'b1, -1,  8'h11, 1'b1, 1'b0, 0};
    vecs[4]  = '{1'b0, 8'h22, 1'b1, -1,  8'h11, 1'b1, 1'b1, 0};
    vecs[5]  = '{1'b1, 8'h00, 1'b1, -1,  8'h11, 1'b0, 1'b0, 0};
    vecs[6]  = '{1'b0, 8'h11, 1'b1, -1,  8'h11, 1'b1, 1'b0, 0};
    vecs[7]  = '{1'b0, 8'h55, 1'b1, 309, 8'h55, 1'b1, 1'b0, 0};
    vecs[8]  = '{1'b1, 8'h00, 1'b1, -1,  8'h55, 1'b0, 1'b0, 0};
    vecs[9]  = '{1'b1, 8'h00, 1'b1, -1,  8'h55, 1'b0, 1'b0, 0};
    vecs[10] = '{1'b0, 8'h66, 1'b1, -1,  8'h66, 1'b1, 1'b0, 0};
    vecs[11] = '{1'b0, 8'h77, 1'b1, -1,  8'h66, 1'b1, 1'b1, 0};

    repeat (3) @(negedge clk);
    chk("reset_data",  32'(rx_data),   32'h0);
    chk("reset_valid", 32'(rx_valid),  32'h0);
    chk("reset_fe",    32'(frame_err), 32'h0);
    chk("reset_ovr",   32'(overrun),   32'h0);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    for (int v = 0; v < 12; v++) begin
      fe0 = fe_hi;
      if (vecs[v].is_ack) do_ack();
      else send_frame(vecs[v].data, vecs[v].stop, vecs[v].ack_at, -1);
      chk($sformatf("v%0d_data", v),  32'(rx_data),  32'(vecs[v].exp_data));
      chk($sformatf("v%0d_valid", v), 32'(rx_valid), 32'(vecs[v].exp_valid));
      chk($sformatf("v%0d_ovr", v),   32'(overrun),  32'(vecs[v].exp_ovr));
      chk($sformatf("v%0d_fe", v),    32'(fe_hi - fe0), 32'(vecs[v].exp_fe));
    end

    // Clear the held word, then a 2-tick glitch must not start a frame.
    do_ack();
    fe0 = fe_hi;
    @(posedge baud8clk);
    rx = 1'b0;
    repeat (8) @(negedge clk);
    rx = 1'b1;
    repeat (64) @(negedge clk);
    chk("false_start_valid", 32'(rx_valid), 32'h0);
    chk("false_start_ovr",   32'(overrun),  32'h0);
    chk("false_start_fe",    32'(fe_hi - fe0), 32'h0);
    send_frame(8'h5A, 1'b1, -1, -1);
    chk("after_false_data",  32'(rx_data),  32'h5A);
    chk("after_false_valid", 32'(rx_valid), 32'h1);

    // Reset during data bit 4 (negedges 160..191) of 0xFF with 0x5A held.
    send_frame(8'hFF, 1'b1, -1, 170);
    chk("post_rst_valid", 32'(rx_valid), 32'h0);
    chk("post_rst_data",  32'(rx_data),  32'h0);
    send_frame(8'h81, 1'b1, -1, -1);
    chk("clean_81_data",  32'(rx_data),  32'h81);
    chk("clean_81_valid", 32'(rx_valid), 32'h1);
    chk("clean_81_ovr",   32'(overrun),  32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
